// File: rtl/jpeg_byte_packer.sv
// jpeg_byte_packer: buffers stuffed 32-bit JPEG words and serialises them to
// bytes MSB-first, then flushes the final partial word and appends the EOI
// marker (FF D9).
// Ports: clk, rst (async, active-high); jpeg_bitstream/data_ready push full
// words; eof_data_partial_ready/end_of_file_bitstream_count latch the tail;
// byte_out/byte_valid/byte_last with byte_ready form the byte stream;
// overflow is sticky on a dropped word; busy flags any work in flight.
module jpeg_byte_packer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] jpeg_bitstream,
   input  logic        data_ready,
   input  logic        eof_data_partial_ready,
   input  logic [4:0]  end_of_file_bitstream_count,
   input  logic        byte_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        byte_last,
   output logic        overflow,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      RUN, TAIL, STUFF, EOI_FF, EOI_D9
   } state_t;

   state_t state, state_nx;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, ld_ptr;
   logic [1:0]    ld_idx;
   logic [CW-1:0] cnt;
   // words not yet fully copied into the output register
   logic [CW-1:0] pend;
   logic          out_eow;

   logic [31:0]   tail_word;
   logic [2:0]    tail_nb;
   logic [2:0]    tail_idx;
   logic          tail_pend;

   logic          full, push, pop, can_load;
   logic [31:0]   src_word;
   logic          src_ok;
   logic [7:0]    tail_byte;
   logic          tail_exh;
   logic [5:0]    nb_sum;

   logic          ld, ld_last, ld_eow;
   logic [7:0]    ld_byte;
   logic          word_adv, word_done, tail_adv, tail_clr;

   assign full      = (cnt == CW'(FIFO_DEPTH));
   // the last byte of a word leaving frees its slot
   assign pop       = byte_valid && byte_ready && out_eow;
   assign push      = data_ready && (!full || pop);
   assign can_load  = !byte_valid || byte_ready;
   // with nothing buffered, the incoming word feeds the output directly
   assign src_ok    = (pend != '0) || push;
   assign src_word  = (pend != '0) ? mem[ld_ptr] : jpeg_bitstream;
   assign tail_exh  = (tail_idx == tail_nb);
   assign word_done = word_adv && (ld_idx == 2'd3);
   assign nb_sum    = {1'b0, end_of_file_bitstream_count} + 6'd7;
   assign busy      = (cnt != '0) || (state != RUN) || byte_valid;

   always_comb begin
      tail_byte = tail_word[31:24];
      unique case (tail_idx[1:0])
         2'd0: tail_byte = tail_word[31:24];
         2'd1: tail_byte = tail_word[23:16];
         2'd2: tail_byte = tail_word[15:8];
         2'd3: tail_byte = tail_word[7:0];
         default: tail_byte = tail_word[31:24];
      endcase
   end

   always_comb begin
      state_nx = state;
      ld       = 1'b0;
      ld_byte  = 8'h00;
      ld_last  = 1'b0;
      ld_eow   = 1'b0;
      word_adv = 1'b0;
      tail_adv = 1'b0;
      tail_clr = 1'b0;
      unique case (state)
         RUN: begin
            if (src_ok) begin
               if (can_load) begin
                  ld       = 1'b1;
                  word_adv = 1'b1;
                  ld_eow   = (ld_idx == 2'd3);
                  unique case (ld_idx)
                     2'd0: ld_byte = src_word[31:24];
                     2'd1: ld_byte = src_word[23:16];
                     2'd2: ld_byte = src_word[15:8];
                     2'd3: ld_byte = src_word[7:0];
                     default: ld_byte = src_word[31:24];
                  endcase
               end
            end else if (tail_pend) begin
               state_nx = (tail_nb != 3'd0) ? TAIL : EOI_FF;
            end
         end
         TAIL: begin
            if (can_load) begin
               ld       = 1'b1;
               ld_byte  = tail_byte;
               tail_adv = 1'b1;
               if (tail_byte == 8'hFF)
                  state_nx = STUFF;
               else if ((tail_idx + 3'd1) == tail_nb)
                  state_nx = EOI_FF;
            end
         end
         STUFF: begin
            if (can_load) begin
               ld       = 1'b1;
               ld_byte  = 8'h00;
               state_nx = tail_exh ? EOI_FF : TAIL;
            end
         end
         EOI_FF: begin
            if (can_load) begin
               ld       = 1'b1;
               ld_byte  = 8'hFF;
               state_nx = EOI_D9;
            end
         end
         EOI_D9: begin
            // D9 stays here until it handshakes, then the tail is retired
            if (byte_valid && byte_last) begin
               if (byte_ready) begin
                  tail_clr = 1'b1;
                  state_nx = RUN;
               end
            end else if (can_load) begin
               ld      = 1'b1;
               ld_byte = 8'hD9;
               ld_last = 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= jpeg_bitstream;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ld_ptr     <= '0;
         ld_idx     <= 2'd0;
         cnt        <= '0;
         pend       <= '0;
         overflow   <= 1'b0;
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         byte_last  <= 1'b0;
         out_eow    <= 1'b0;
         tail_word  <= 32'h0;
         tail_nb    <= 3'd0;
         tail_idx   <= 3'd0;
         tail_pend  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt  <= cnt + CW'(push) - CW'(pop);
         pend <= pend + CW'(push) - CW'(word_done);
         if (data_ready && !push) overflow <= 1'b1;
         if (word_adv) begin
            ld_idx <= ld_idx + 2'd1;
            if (word_done) ld_ptr <= ld_ptr + 1'b1;
         end
         if (can_load) begin
            byte_valid <= ld;
            byte_last  <= ld_last;
            out_eow    <= ld_eow;
            if (ld) byte_out <= ld_byte;
         end
         if (tail_clr) begin
            tail_pend <= 1'b0;
            tail_idx  <= 3'd0;
         end else if (eof_data_partial_ready && !tail_pend) begin
            tail_pend <= 1'b1;
            // bits past the valid count read as 1s
            tail_word <= jpeg_bitstream
                       | (32'hFFFF_FFFF >> end_of_file_bitstream_count);
            tail_nb   <= nb_sum[5:3];
            tail_idx  <= 3'd0;
         end else if (tail_adv) begin
            tail_idx <= tail_idx + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Directed bench for jpeg_byte_packer.
// Collects handshaken bytes and compares them with hand-computed sequences.
module tb_jpeg_byte_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] jpeg_bitstream = 32'h0;
   logic        data_ready = 1'b0;
   logic        eof_data_partial_ready = 1'b0;
   logic [4:0]  end_of_file_bitstream_count = 5'd0;
   logic        byte_ready = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_last;
   logic        overflow;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit rnd = 1'b0;

   logic [7:0] got_q[$];
   logic       got_last[$];
   int         got_cyc[$];
   logic [7:0] exp_q[$];

   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic       pl = 1'b0;
   logic [7:0] pb = 8'h00;

   jpeg_byte_packer #(.FIFO_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .jpeg_bitstream(jpeg_bitstream),
      .data_ready(data_ready),
      .eof_data_partial_ready(eof_data_partial_ready),
      .end_of_file_bitstream_count(end_of_file_bitstream_count),
      .byte_ready(byte_ready),
      .byte_out(byte_out),
      .byte_valid(byte_valid),
      .byte_last(byte_last),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr)
            chk("stall_hold", {22'h0, byte_last, byte_valid, byte_out},
                {22'h0, pl, 1'b1, pb});
         if (byte_valid && byte_ready) begin
            got_q.push_back(byte_out);
            got_last.push_back(byte_last);
            got_cyc.push_back(cyc);
         end
         pv = byte_valid;
         pr = byte_ready;
         pl = byte_last;
         pb = byte_out;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      got_q.delete();
      got_last.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   task automatic send(input logic [31:0] w, input bit dr, input bit eof,
                       input logic [4:0] c);
      jpeg_bitstream = w;
      data_ready = dr;
      eof_data_partial_ready = eof;
      end_of_file_bitstream_count = c;
      step();
      data_ready = 1'b0;
      eof_data_partial_ready = 1'b0;
   endtask

   task automatic check_out(input string tag, input bit last_exp);
      for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) begin
         if (rnd) byte_ready = 1'($urandom_range(0, 1));
         step();
      end
      byte_ready = 1'b1;
      repeat (4) step();
      chk({tag, "_n"}, got_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got_q.size()) begin
            chk($sformatf("%s_b%0d", tag, i), {24'h0, got_q[i]},
                {24'h0, exp_q[i]});
            chk($sformatf("%s_l%0d", tag, i), {31'h0, got_last[i]},
                {31'h0, last_exp && (i == exp_q.size() - 1)});
         end
      end
   endtask

   initial begin
      #2;
      chk("rst_out", {24'h0, byte_out}, 32'h0);
      chk("rst_flags", {28'h0, byte_valid, byte_last, overflow, busy}, 32'h0);
      step();
      rst = 1'b0;
      byte_ready = 1'b1;
      step();

      // single word, first byte one cycle after data_ready
      clr();
      send(32'h12345678, 1'b1, 1'b0, 5'd0);
      chk("t1_first_v", {31'h0, byte_valid}, 32'h1);
      chk("t1_first_b", {24'h0, byte_out}, 32'h12);
      exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      check_out("t1", 1'b0);
      if (got_cyc.size() >= 4)
         chk("t1_consec", got_cyc[3] - got_cyc[0], 32'd3);
      else
         chk("t1_consec_n", got_cyc.size(), 32'd4);
      chk("t1_idle", {31'h0, busy}, 32'h0);

      // tail with 12 valid bits
      clr();
      send(32'hABC00000, 1'b0, 1'b1, 5'd12);
      exp_q = '{8'hAB, 8'hCF, 8'hFF, 8'hD9};
      check_out("t2", 1'b1);

      // padded tail becomes FF and gets stuffed
      clr();
      send(32'hFE000000, 1'b0, 1'b1, 5'd7);
      exp_q = '{8'hFF, 8'h00, 8'hFF, 8'hD9};
      check_out("t3", 1'b1);

      // word and empty tail in the same cycle
      clr();
      send(32'h01020304, 1'b1, 1'b1, 5'd0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
      check_out("t4", 1'b1);

      // overflow with stalled output
      clr();
      byte_ready = 1'b0;
      send(32'h10111213, 1'b1, 1'b0, 5'd0);
      send(32'h20212223, 1'b1, 1'b0, 5'd0);
      send(32'h30313233, 1'b1, 1'b0, 5'd0);
      send(32'h40414243, 1'b1, 1'b0, 5'd0);
      chk("t5_no_ovf", {31'h0, overflow}, 32'h0);
      send(32'h50515253, 1'b1, 1'b0, 5'd0);
      chk("t5_ovf", {31'h0, overflow}, 32'h1);
      repeat (3) step();
      chk("t5_hold", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'h10});
      chk("t5_busy", {31'h0, busy}, 32'h1);
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
      byte_ready = 1'b1;
      check_out("t5", 1'b0);
      chk("t5_ovf_sticky", {31'h0, overflow}, 32'h1);

      // random backpressure across word, tail and EOI
      clr();
      rnd = 1'b1;
      byte_ready = 1'b0;
      send(32'hA1B2C3D4, 1'b1, 1'b0, 5'd0);
      send(32'hABC00000, 1'b0, 1'b1, 5'd12);
      exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hAB, 8'hCF, 8'hFF, 8'hD9};
      check_out("t6", 1'b1);
      rnd = 1'b0;

      // reset while the EOI FF is waiting to be loaded
      clr();
      byte_ready = 1'b0;
      send(32'hABC00000, 1'b0, 1'b1, 5'd12);
      for (int i = 0; i < 20 && !byte_valid; i++) step();
      chk("t7_ab", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hAB});
      byte_ready = 1'b1;
      step();
      byte_ready = 1'b0;
      chk("t7_cf", {23'h0, byte_valid, byte_out}, {23'h0, 1'b1, 8'hCF});
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      chk("t7_rst", {29'h0, byte_valid, overflow, busy}, 32'h0);
      chk("t7_rst_b", {24'h0, byte_out}, 32'h0);
      step();
      rst = 1'b0;
      byte_ready = 1'b1;
      got_q.delete();
      got_last.delete();
      got_cyc.delete();
      repeat (10) step();
      chk("t7_quiet", got_q.size(), 32'd0);

      // normal operation after reset
      clr();
      send(32'h5A5AA5A5, 1'b1, 1'b0, 5'd0);
      exp_q = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
      check_out("t8", 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
